// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin arbiter sharing one multicycle ALU between two lanes
module alu_share_arbiter #(
    parameter int LAT_SIMPLE = 1,
    parameter int LAT_MUL    = 2,
    parameter int LAT_DIV    = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [3:0]  req_op0,
    input  logic [3:0]  req_op1,
    input  logic [23:0] req_a0,
    input  logic [23:0] req_a1,
    input  logic [23:0] req_b0,
    input  logic [23:0] req_b1,
    output logic [23:0] alu_reg1,
    output logic [23:0] alu_reg2,
    output logic [3:0]  alu_operation,
    input  logic [23:0] alu_result,
    input  logic [3:0]  alu_flags,
    output logic [1:0]  rsp_valid,
    output logic [23:0] rsp_result,
    output logic [3:0]  rsp_flags,
    output logic        rsp_dz,
    output logic        busy
);

    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_DIV = 4'b0011;
    localparam logic [3:0] OP_MOD = 4'b0100;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state;
    logic [7:0]  cnt;
    logic        owner;
    logic        last_grant;
    logic        grant;
    logic        accept;
    logic [3:0]  op_q;
    logic [23:0] a_q;
    logic [23:0] b_q;
    logic [3:0]  sel_op;
    logic [23:0] sel_a;
    logic [23:0] sel_b;

    // Settle cycles minus one, loaded into the countdown on accept.
    function automatic logic [7:0] lat_m1(input logic [3:0] op);
        case (op)
            OP_MUL:         return 8'(LAT_MUL - 1);
            OP_DIV, OP_MOD: return 8'(LAT_DIV - 1);
            default:        return 8'(LAT_SIMPLE - 1);
        endcase
    endfunction

    // Grant: a lone valid lane wins; on contention the lane that did not win last time wins.
    always_comb begin
        grant = 1'b0;
        case (req_valid)
            2'b10:   grant = 1'b1;
            2'b11:   grant = ~last_grant;
            default: grant = 1'b0;
        endcase
    end

    assign req_ready = (state == IDLE && req_valid != 2'b00) ? (grant ? 2'b10 : 2'b01) : 2'b00;
    assign accept    = (req_valid & req_ready) != 2'b00;
    assign sel_op    = grant ? req_op1 : req_op0;
    assign sel_a     = grant ? req_a1  : req_a0;
    assign sel_b     = grant ? req_b1  : req_b0;

    // The ALU always sees the operand registers, stale or not.
    assign alu_operation = op_q;
    assign alu_reg1      = a_q;
    assign alu_reg2      = b_q;
    assign busy          = (state != IDLE);

    // Accept, hold operands for the opcode's settle time, then capture and pulse the owner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 8'd0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            op_q       <= 4'd0;
            a_q        <= 24'd0;
            b_q        <= 24'd0;
            rsp_valid  <= 2'b00;
            rsp_result <= 24'd0;
            rsp_flags  <= 4'd0;
            rsp_dz     <= 1'b0;
        end else begin
            rsp_valid <= 2'b00;
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q       <= sel_op;
                        a_q        <= sel_a;
                        b_q        <= sel_b;
                        owner      <= grant;
                        last_grant <= grant;
                        cnt        <= lat_m1(sel_op);
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt == 8'd0) begin
                        rsp_result <= alu_result;
                        rsp_flags  <= alu_flags;
                        rsp_dz     <= (op_q == OP_DIV || op_q == OP_MOD) && (b_q == 24'd0);
                        rsp_valid  <= owner ? 2'b10 : 2'b01;
                        state      <= IDLE;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - directed self-checking bench for alu_share_arbiter
module tb_alu_share_arbiter;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd3;
    localparam logic [3:0] OP_MOD = 4'd4;
    localparam logic [3:0] OP_AND = 4'd5;
    localparam logic [3:0] OP_OR  = 4'd6;
    localparam logic [3:0] OP_UND = 4'hF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_ready;
    logic [3:0]  req_op0 = 4'd0, req_op1 = 4'd0;
    logic [23:0] req_a0 = 24'd0, req_a1 = 24'd0, req_b0 = 24'd0, req_b1 = 24'd0;
    logic [23:0] alu_reg1, alu_reg2, alu_result;
    logic [3:0]  alu_operation, alu_flags;
    logic [1:0]  rsp_valid;
    logic [23:0] rsp_result;
    logic [3:0]  rsp_flags;
    logic        rsp_dz;
    logic        busy;

    int n_cmp = 0;
    int n_fail = 0;

    alu_share_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op0(req_op0), .req_op1(req_op1),
        .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
        .alu_reg1(alu_reg1), .alu_reg2(alu_reg2), .alu_operation(alu_operation),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_flags(rsp_flags),
        .rsp_dz(rsp_dz), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: flags are {z,n,v,c}; divide by zero yields 0.
    always_comb begin
        logic signed [23:0] sa;
        logic signed [23:0] sb;
        logic signed [47:0] prod;
        logic [24:0] wide;
        logic [23:0] res;
        logic v;
        logic c;
        sa = alu_reg1;
        sb = alu_reg2;
        prod = 48'sd0;
        wide = 25'd0;
        res = 24'd0;
        v = 1'b0;
        c = 1'b0;
        case (alu_operation)
            OP_ADD: begin
                wide = {1'b0, alu_reg1} + {1'b0, alu_reg2};
                res = wide[23:0];
                c = wide[24];
                v = (alu_reg1[23] == alu_reg2[23]) && (res[23] != alu_reg1[23]);
            end
            OP_SUB: begin
                wide = {1'b0, alu_reg1} - {1'b0, alu_reg2};
                res = wide[23:0];
                c = wide[24];
                v = (alu_reg1[23] != alu_reg2[23]) && (res[23] != alu_reg1[23]);
            end
            OP_MUL: begin
                prod = sa * sb;
                res = prod[23:0];
            end
            OP_DIV: res = (alu_reg2 == 24'd0) ? 24'd0 : 24'(sa / sb);
            OP_MOD: res = (alu_reg2 == 24'd0) ? 24'd0 : 24'(sa % sb);
            OP_AND: res = alu_reg1 & alu_reg2;
            OP_OR:  res = alu_reg1 | alu_reg2;
            default: res = 24'd0;
        endcase
        alu_result = res;
        alu_flags = {res == 24'd0, res[23], v, c};
    end

    task automatic test_reset;
        rst_n = 1'b0;
        req_valid = 2'b00;
        #1;
        n_cmp++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b want 00", req_ready); end
        n_cmp++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 00", rsp_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if ({alu_reg1, alu_reg2, alu_operation} !== 52'd0) begin n_fail++; $display("FAIL reset_alu_regs: got %h %h %h want 0", alu_reg1, alu_reg2, alu_operation); end
        n_cmp++; if ({rsp_result, rsp_flags, rsp_dz} !== 29'd0) begin n_fail++; $display("FAIL reset_rsp: got %h %h %b want 0", rsp_result, rsp_flags, rsp_dz); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_add_lane0;
        req_valid = 2'b01; req_op0 = OP_ADD; req_a0 = 24'd5; req_b0 = -24'sd7;
        #1;
        n_cmp++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL add_ready: got %b want 01", req_ready); end
        @(posedge clk); #1;
        req_valid = 2'b00;
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL add_busy: got %b want 1", busy); end
        n_cmp++; if ({alu_operation, alu_reg1, alu_reg2} !== {OP_ADD, 24'd5, 24'hFFFFF9}) begin n_fail++; $display("FAIL add_alu_in: got %h %h %h want 0 000005 fffff9", alu_operation, alu_reg1, alu_reg2); end
        n_cmp++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL add_rsp_early: got %b want 00", rsp_valid); end
        @(posedge clk); #1;
        n_cmp++; if (rsp_valid !== 2'b01) begin n_fail++; $display("FAIL add_rsp_valid: got %b want 01", rsp_valid); end
        n_cmp++; if (rsp_result !== 24'hFFFFFE) begin n_fail++; $display("FAIL add_result: got %h want fffffe", rsp_result); end
        n_cmp++; if (rsp_flags !== 4'b0100) begin n_fail++; $display("FAIL add_flags: got %b want 0100", rsp_flags); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL add_busy_end: got %b want 0", busy); end
        @(posedge clk); #1;
        n_cmp++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL add_rsp_pulse: got %b want 00", rsp_valid); end
        n_cmp++; if (rsp_result !== 24'hFFFFFE) begin n_fail++; $display("FAIL add_result_hold: got %h want fffffe", rsp_result); end
    endtask

    task automatic test_div_lane1;
        req_valid = 2'b10; req_op1 = OP_DIV; req_a1 = 24'd100; req_b1 = 24'd7;
        #1;
        n_cmp++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL div_ready: got %b want 10", req_ready); end
        @(posedge clk); #1;
        req_valid = 2'b00;
        req_a1 = 24'd55; req_b1 = 24'd0; req_op1 = OP_ADD;
        for (int k = 0; k < 5; k++) begin
            n_cmp++; if ({alu_operation, alu_reg1, alu_reg2} !== {OP_DIV, 24'd100, 24'd7}) begin n_fail++; $display("FAIL div_hold%0d: got %h %h %h want 3 000064 000007", k, alu_operation, alu_reg1, alu_reg2); end
            n_cmp++; if ({busy, rsp_valid} !== 3'b100) begin n_fail++; $display("FAIL div_wait%0d: got busy=%b rsp=%b want 1 00", k, busy, rsp_valid); end
            @(posedge clk); #1;
        end
        n_cmp++; if ({alu_operation, alu_reg1, alu_reg2} !== {OP_DIV, 24'd100, 24'd7}) begin n_fail++; $display("FAIL div_hold5: got %h %h %h want 3 000064 000007", alu_operation, alu_reg1, alu_reg2); end
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL div_busy5: got %b want 1", busy); end
        @(posedge clk); #1;
        n_cmp++; if (rsp_valid !== 2'b10) begin n_fail++; $display("FAIL div_rsp_valid: got %b want 10", rsp_valid); end
        n_cmp++; if (rsp_result !== 24'd14) begin n_fail++; $display("FAIL div_result: got %0d want 14", rsp_result); end
        n_cmp++; if (rsp_dz !== 1'b0) begin n_fail++; $display("FAIL div_dz: got %b want 0", rsp_dz); end
        @(posedge clk); #1;
    endtask

    task automatic test_round_robin;
        logic [1:0] exp_rdy;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        req_valid = 2'b11;
        req_op0 = OP_MUL; req_a0 = 24'd3; req_b0 = 24'd4;
        req_op1 = OP_SUB; req_a1 = 24'd10; req_b1 = 24'd10;
        #1;
        n_cmp++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL rr_first_grant: got %b want 01", req_ready); end
        @(posedge clk); #1;
        req_valid = 2'b10;
        n_cmp++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL rr_ready_busy: got %b want 00", req_ready); end
        @(posedge clk); #1;
        n_cmp++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL rr_mul_early: got %b want 00", rsp_valid); end
        @(posedge clk); #1;
        n_cmp++; if (rsp_valid !== 2'b01) begin n_fail++; $display("FAIL rr_mul_rsp: got %b want 01", rsp_valid); end
        n_cmp++; if (rsp_result !== 24'd12) begin n_fail++; $display("FAIL rr_mul_result: got %0d want 12", rsp_result); end
        n_cmp++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL rr_b2b_ready: got %b want 10", req_ready); end
        @(posedge clk); #1;
        req_valid = 2'b00;
        n_cmp++; if ({busy, alu_operation} !== {1'b1, OP_SUB}) begin n_fail++; $display("FAIL rr_sub_accept: got busy=%b op=%h want 1 1", busy, alu_operation); end
        @(posedge clk); #1;
        n_cmp++; if (rsp_valid !== 2'b10) begin n_fail++; $display("FAIL rr_sub_rsp: got %b want 10", rsp_valid); end
        n_cmp++; if ({rsp_result, rsp_flags[3]} !== {24'd0, 1'b1}) begin n_fail++; $display("FAIL rr_sub_result: got %h z=%b want 0 z=1", rsp_result, rsp_flags[3]); end
        req_valid = 2'b11;
        req_op0 = OP_ADD; req_a0 = 24'd1; req_b0 = 24'd1;
        req_op1 = OP_ADD; req_a1 = 24'd2; req_b1 = 24'd3;
        for (int i = 0; i < 4; i++) begin
            exp_rdy = (i % 2 == 0) ? 2'b01 : 2'b10;
            #1;
            n_cmp++; if (req_ready !== exp_rdy) begin n_fail++; $display("FAIL rr_alt_grant%0d: got %b want %b", i, req_ready, exp_rdy); end
            @(posedge clk); #1;
            @(posedge clk); #1;
            n_cmp++; if (rsp_valid !== exp_rdy) begin n_fail++; $display("FAIL rr_alt_rsp%0d: got %b want %b", i, rsp_valid, exp_rdy); end
            n_cmp++; if (rsp_result !== ((i % 2 == 0) ? 24'd2 : 24'd5)) begin n_fail++; $display("FAIL rr_alt_result%0d: got %0d", i, rsp_result); end
        end
        req_valid = 2'b00;
        @(posedge clk); #1;
    endtask

    task automatic test_mod_zero;
        req_valid = 2'b01; req_op0 = OP_MOD; req_a0 = 24'd9; req_b0 = 24'd0;
        @(posedge clk); #1;
        req_valid = 2'b00;
        for (int k = 0; k < 5; k++) begin
            n_cmp++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL mod_early%0d: got %b want 00", k, rsp_valid); end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        n_cmp++; if (rsp_valid !== 2'b01) begin n_fail++; $display("FAIL mod_rsp_valid: got %b want 01", rsp_valid); end
        n_cmp++; if ({rsp_result, rsp_flags, rsp_dz} !== {24'd0, 4'b1000, 1'b1}) begin n_fail++; $display("FAIL mod_dz: got %h %b %b want 0 1000 1", rsp_result, rsp_flags, rsp_dz); end
        @(posedge clk); #1;
        n_cmp++; if (rsp_dz !== 1'b1) begin n_fail++; $display("FAIL mod_dz_hold: got %b want 1", rsp_dz); end
    endtask

    task automatic test_reset_mid_div;
        req_valid = 2'b01; req_op0 = OP_DIV; req_a0 = 24'd100; req_b0 = 24'd7;
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({busy, rsp_valid, req_ready} !== 5'd0) begin n_fail++; $display("FAIL rst_mid_ctrl: got busy=%b rsp=%b rdy=%b want 0", busy, rsp_valid, req_ready); end
        n_cmp++; if ({alu_operation, alu_reg1, alu_reg2} !== 52'd0) begin n_fail++; $display("FAIL rst_mid_alu: got %h %h %h want 0", alu_operation, alu_reg1, alu_reg2); end
        n_cmp++; if ({rsp_result, rsp_flags, rsp_dz} !== 29'd0) begin n_fail++; $display("FAIL rst_mid_rsp: got %h %h %b want 0", rsp_result, rsp_flags, rsp_dz); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            n_cmp++; if ({busy, rsp_valid} !== 3'b000) begin n_fail++; $display("FAIL rst_mid_no_rsp%0d: got busy=%b rsp=%b want 0 00", k, busy, rsp_valid); end
        end
        req_valid = 2'b11;
        req_op0 = OP_ADD; req_a0 = 24'd20; req_b0 = 24'd22;
        req_op1 = OP_OR;  req_a1 = 24'h0F0; req_b1 = 24'h00F;
        #1;
        n_cmp++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL rst_mid_lane0_first: got %b want 01", req_ready); end
        @(posedge clk); #1;
        req_valid = 2'b10;
        @(posedge clk); #1;
        n_cmp++; if ({rsp_valid, rsp_result} !== {2'b01, 24'd42}) begin n_fail++; $display("FAIL rst_mid_after: got %b %0d want 01 42", rsp_valid, rsp_result); end
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(posedge clk); #1;
        n_cmp++; if ({rsp_valid, rsp_result} !== {2'b10, 24'h0FF}) begin n_fail++; $display("FAIL rst_mid_lane1: got %b %h want 10 0000ff", rsp_valid, rsp_result); end
    endtask

    task automatic test_undef_lane1;
        req_valid = 2'b10; req_op1 = OP_UND; req_a1 = 24'd1; req_b1 = 24'd1;
        @(posedge clk); #1;
        req_valid = 2'b00;
        n_cmp++; if ({busy, rsp_valid} !== 3'b100) begin n_fail++; $display("FAIL undef_busy: got busy=%b rsp=%b want 1 00", busy, rsp_valid); end
        @(posedge clk); #1;
        n_cmp++; if (rsp_valid !== 2'b10) begin n_fail++; $display("FAIL undef_rsp_valid: got %b want 10", rsp_valid); end
        n_cmp++; if ({rsp_result, rsp_flags, rsp_dz} !== {24'd0, 4'b1000, 1'b0}) begin n_fail++; $display("FAIL undef_result: got %h %b %b want 0 1000 0", rsp_result, rsp_flags, rsp_dz); end
    endtask

    initial begin
        test_reset();
        test_add_lane0();
        test_div_lane1();
        test_round_robin();
        test_mod_zero();
        test_reset_mid_div();
        test_undef_lane1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
